instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache sitting between the CPU fetch port (PC_OUT -> INSTRUCTION) and
//  the block-oriented instruction memory. Returns the 32-bit instruction at the CPU's PC in the same cycle on
//  a hit. On a miss it raises BUSYWAIT so the CPU stalls, fetches a 16-byte block, installs it, then releases.
// PARAMETERS
//  ADDR_W        10  byte-address bits used from PC; upper PC bits ignored (address wraps modulo 1 KiB)
//  NUM_BLOCKS     8  cache lines (index width = log2 = 3)
//  WORDS_PER_BLK  4  32-bit words per line (word-offset width = 2; line = 128 bits)
// PORTS
//  CLK            in   1    system clock; all state updates on posedge
//  RESET          in   1    asynchronous, active-high reset
//  PC             in   32   fetch byte address from CPU; PC[1:0] ignored (word aligned)
//  INSTRUCTION    out  32   instruction word for PC; valid when BUSYWAIT=0
//  BUSYWAIT       out  1    1 = CPU must stall (miss in progress)
//  mem_read       out  1    read request to instruction memory
//  mem_address    out  6    block address to memory = {tag,index} of the missing line
//  mem_readdata   in   128  returned block; word0 at [31:0], word3 at [127:96]
//  mem_busywait   in   1    1 = memory still servicing the request
// BEHAVIOUR
//  - Address split (ADDR_W=10): PC[3:2] word offset, PC[6:4] index, PC[9:7] tag.
//  - Per line: valid bit, 3-bit tag, 128-bit data. hit = valid[idx] && tag[idx]==PC[9:7]; combinational.
//  - INSTRUCTION = data[idx] word PC[3:2], combinational; drives 32'h0 while BUSYWAIT=1 or in reset.
//  - FSM states IDLE, MEM_READ, UPDATE:
//    IDLE: BUSYWAIT = !hit (combinational); on posedge with !hit latch {tag,index} -> MEM_READ.
//    MEM_READ: mem_read=1, mem_address=latched block addr, BUSYWAIT=1; stay while mem_busywait=1;
//      on posedge with mem_busywait=0 capture mem_readdata -> UPDATE.
//    UPDATE: BUSYWAIT=1, mem_read=0; on posedge write data, tag, valid=1 into latched index -> IDLE.
//    The first IDLE cycle after UPDATE is a hit for the stalled PC (BUSYWAIT drops that cycle).
//  - Miss latency seen by CPU: 1 (IDLE detect) + N memory cycles + 1 (UPDATE) cycles of BUSYWAIT.
//  - Fill uses the latched address; PC changes during MEM_READ/UPDATE do not alter the fill.
//  - Conflict miss: new tag overwrites line unconditionally (no dirty state, read-only).
//  - RESET (any state, incl. mid-fill): state=IDLE, all valid=0, latched addr=0, mem_read=0,
//    mem_address=0; in-flight memory data is discarded. BUSYWAIT=0, INSTRUCTION=0 while RESET high.
//  - After reset deassert every access misses until its line is filled (cold start).
//  - mem_readdata sampled only in MEM_READ when mem_busywait=0; ignored otherwise.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_count[15:0], miss_count[15:0]. miss_count += 1 on each
//    IDLE->MEM_READ transition; hit_count += 1 on each posedge in IDLE with hit=1. Both saturate at 16'hFFFF
//    and clear on RESET.
//  Not defined: ports and counters absent; functional behaviour otherwise identical.
// STRUCTURE
//  Shared package cpu_mem_pkg: ICACHE state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2), line width
//    (128), block-address width (6), field-position localparams for tag/index/offset.
//  One sub-module: icache_tag_array (valid+tag storage, hit compare, async clear on RESET); data array
//    and FSM stay in instr_cache.
// TESTING
//  1 Cold miss: RESET then PC=0; memory block0 = {W3,W2,W1,32'hAABB0001}, mem_busywait 5 cycles -> BUSYWAIT
//    high, mem_read=1 with mem_address=0, BUSYWAIT low after UPDATE with INSTRUCTION=32'hAABB0001.
//  2 Sequential hits: PC=4,8,12 after test 1 -> BUSYWAIT=0 each cycle, INSTRUCTION=W1,W2,W3, mem_read=0.
//  3 Next line: PC=16 -> miss, mem_address=6'd1; after fill INSTRUCTION=block1 word0; line 0 still hits.
//  4 Conflict: PC=0x080 (tag1,index0) -> miss, mem_address=6'd8, line replaced; PC=0 then misses again.
//  5 Reset mid-fill: assert RESET during MEM_READ -> mem_read=0, BUSYWAIT=0 at once; after release PC=0
//    misses again (valid cleared) and fill completes normally.
//  6 ICACHE_STATS_EN: run tests 1-3 -> miss_count=2, hit_count=5 (stalled-PC hit after each fill + 3 hits);
//    force 65536 hits -> hit_count holds 16'hFFFF.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction-side memory hierarchy:
// cache state encoding, line/word geometry, and PC field positions.
package cpu_mem_pkg;

  localparam int ADDR_W        = 10;
  localparam int NUM_BLOCKS    = 8;
  localparam int WORDS_PER_BLK = 4;
  localparam int WORD_W        = 32;
  localparam int LINE_W        = 128;
  localparam int OFF_W         = 2;
  localparam int IDX_W         = 3;
  localparam int TAG_W         = 3;
  localparam int BLK_ADDR_W    = 6;
  localparam int STAT_W        = 16;

  // Bit positions of the fields inside the byte address
  localparam int OFF_LSB = 2;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } icache_state_t;

  // Select one 32-bit word out of a 128-bit line; word0 sits in the low bits
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped instruction cache, with the
// combinational hit compare. RESET clears every valid bit asynchronously.
module icache_tag_array
  import cpu_mem_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_index,
  input  logic [TAG_W-1:0] write_tag
);

  logic [NUM_BLOCKS-1:0] valid_reg;
  logic [TAG_W-1:0]      tag_reg [NUM_BLOCKS];

  // Install the tag of a freshly filled line and mark it valid
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_reg <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_reg[i] <= '0;
      end
    end else if (write_en) begin
      valid_reg[write_index] <= 1'b1;
      tag_reg[write_index]   <= write_tag;
    end
  end

  // Hit when the indexed line holds the requested tag
  always_comb begin
    hit = valid_reg[lookup_index] && (tag_reg[lookup_index] == lookup_tag);
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 4 words, combinational
// hit path, stall-and-fill on a miss through a three-state FSM.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module instr_cache
  import cpu_mem_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  mem_read,
  output logic [BLK_ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0]     mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]     hit_count,
  output logic [STAT_W-1:0]     miss_count
`endif
);

  // Address fields; bits above the 1 KiB window and the byte offset are ignored
  logic [OFF_W-1:0] pc_offset;
  logic [IDX_W-1:0] pc_index;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_bits;

  assign pc_offset      = PC[IDX_LSB-1:OFF_LSB];
  assign pc_index       = PC[TAG_LSB-1:IDX_LSB];
  assign pc_tag         = PC[ADDR_W-1:TAG_LSB];
  assign unused_pc_bits = ^{PC[31:ADDR_W], PC[OFF_LSB-1:0]};

  icache_state_t           state_reg, state_next;
  logic [BLK_ADDR_W-1:0]   blk_addr_reg;
  logic [LINE_W-1:0]       fill_data_reg;
  logic [LINE_W-1:0]       data_reg [NUM_BLOCKS];
  logic                    hit;
  logic                    busy_fsm;
  logic                    fill_we;
  logic [IDX_W-1:0]        fill_index;
  logic [TAG_W-1:0]        fill_tag;

  assign fill_we    = (state_reg == UPDATE);
  assign fill_index = blk_addr_reg[IDX_W-1:0];
  assign fill_tag   = blk_addr_reg[BLK_ADDR_W-1:IDX_W];

  icache_tag_array u_tag_array (
    .CLK          (CLK),
    .RESET        (RESET),
    .lookup_index (pc_index),
    .lookup_tag   (pc_tag),
    .hit          (hit),
    .write_en     (fill_we),
    .write_index  (fill_index),
    .write_tag    (fill_tag)
  );

  // State register plus the latched miss address and the captured memory block
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      blk_addr_reg  <= '0;
      fill_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && !hit) begin
        blk_addr_reg <= {pc_tag, pc_index};
      end
      if (state_reg == MEM_READ && !mem_busywait) begin
        fill_data_reg <= mem_readdata;
      end
    end
  end

  // Line data needs no reset: the valid bits guard every read
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      data_reg[fill_index] <= fill_data_reg;
    end
  end

  // Next-state and memory-side outputs; the fill always targets the latched address
  always_comb begin
    state_next  = state_reg;
    busy_fsm    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_reg)
      IDLE: begin
        busy_fsm = !hit;
        if (!hit) begin
          state_next = MEM_READ;
        end
      end
      MEM_READ: begin
        busy_fsm    = 1'b1;
        mem_read    = 1'b1;
        mem_address = blk_addr_reg;
        if (!mem_busywait) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        busy_fsm   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // CPU-side outputs are forced quiet while RESET is held
  always_comb begin
    BUSYWAIT    = busy_fsm && !RESET;
    INSTRUCTION = '0;
    if (!RESET && !busy_fsm) begin
      INSTRUCTION = line_word(data_reg[pc_index], pc_offset);
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters: a hit per IDLE cycle with a hit, a miss per fill start
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_reg == IDLE) begin
      if (hit) begin
        if (hit_count != {STAT_W{1'b1}}) begin
          hit_count <= hit_count + 1'b1;
        end
      end else begin
        if (miss_count != {STAT_W{1'b1}}) begin
          miss_count <= miss_count + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed cold/sequential/conflict/
// reset-mid-fill scenarios followed by randomized fetches, all checked against
// a line-level model (valid/tag per index, block memory array, counters).
// Define ICACHE_STATS_EN for both bench and RTL to exercise the counters.
module tb_instr_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: block memory plus what each cache index currently holds
  logic [127:0] mem_blk [64];
  logic         m_valid [8];
  logic [2:0]   m_tag   [8];
  int           m_hits;
  int           m_misses;
  int           n_checks;
  int           n_pass;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One CPU fetch starting #1 after a posedge with the cache idle; k = extra
  // memory busy cycles; scramble wiggles PC while the fill is under way.
  task automatic fetch(input logic [31:0] pc, input int k, input bit scramble);
    logic [5:0]  blk;
    logic [2:0]  idx;
    logic [2:0]  tg;
    logic [1:0]  off;
    logic [31:0] word;
    logic [127:0] line;
    bit          exp_hit;
    blk  = pc[9:4];
    idx  = pc[6:4];
    tg   = pc[9:7];
    off  = pc[3:2];
    line = mem_blk[blk];
    word = line[off*32 +: 32];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    PC = pc;
    mem_busywait = 1'b1;
    mem_readdata = rand_line();
    $display("fetch pc=%h blk=%0d expect_hit=%0d k=%0d", pc, blk, exp_hit, k);
    @(negedge CLK);
    if (exp_hit) begin
      chk("hit_busywait", {127'd0, BUSYWAIT}, 128'd0);
      chk("hit_instr", {96'd0, INSTRUCTION}, {96'd0, word});
      chk("hit_memread", {127'd0, mem_read}, 128'd0);
      @(posedge CLK); #1;
      m_hits = sat_inc(m_hits);
      return;
    end
    chk("miss_busywait", {127'd0, BUSYWAIT}, 128'd1);
    chk("miss_instr_zero", {96'd0, INSTRUCTION}, 128'd0);
    chk("miss_detect_memread", {127'd0, mem_read}, 128'd0);
    @(posedge CLK); #1;
    m_misses = sat_inc(m_misses);
    for (int c = 0; c < k; c++) begin
      if (scramble) PC = $urandom();
      mem_busywait = 1'b1;
      mem_readdata = rand_line();
      @(negedge CLK);
      chk("wait_memread", {127'd0, mem_read}, 128'd1);
      chk("wait_addr", {122'd0, mem_address}, {122'd0, blk});
      chk("wait_busywait", {127'd0, BUSYWAIT}, 128'd1);
      @(posedge CLK); #1;
    end
    if (scramble) PC = $urandom();
    mem_busywait = 1'b0;
    mem_readdata = mem_blk[blk];
    @(negedge CLK);
    chk("ret_memread", {127'd0, mem_read}, 128'd1);
    chk("ret_addr", {122'd0, mem_address}, {122'd0, blk});
    @(posedge CLK); #1;
    // UPDATE cycle: memory data now garbage, PC back to the stalled address
    PC = pc;
    mem_busywait = 1'b1;
    mem_readdata = rand_line();
    @(negedge CLK);
    chk("upd_busywait", {127'd0, BUSYWAIT}, 128'd1);
    chk("upd_memread", {127'd0, mem_read}, 128'd0);
    @(posedge CLK); #1;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(negedge CLK);
    chk("fill_busywait", {127'd0, BUSYWAIT}, 128'd0);
    chk("fill_instr", {96'd0, INSTRUCTION}, {96'd0, word});
    @(posedge CLK); #1;
    m_hits = sat_inc(m_hits);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic check_stats(input string where);
    chk({where, "_hits"},   {112'd0, hit_count},  {112'd0, 16'(m_hits)});
    chk({where, "_misses"}, {112'd0, miss_count}, {112'd0, 16'(m_misses)});
  endtask
`endif

  initial begin
    logic [31:0] pc;
    n_checks = 0;
    n_pass   = 0;
    for (int b = 0; b < 64; b++) mem_blk[b] = rand_line();
    mem_blk[0][31:0] = 32'hAABB0001;
    model_reset();
    PC = 32'd0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    RESET = 1'b0;
    #2 RESET = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
    chk("rst_instr", {96'd0, INSTRUCTION}, 128'd0);
    chk("rst_memread", {127'd0, mem_read}, 128'd0);
    chk("rst_addr", {122'd0, mem_address}, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Cold miss, sequential hits, next line, line 0 still resident
    fetch(32'h0, 5, 1'b0);
    fetch(32'h4, 0, 1'b0);
    fetch(32'h8, 0, 1'b0);
    fetch(32'hC, 0, 1'b0);
    fetch(32'h10, 2, 1'b0);
`ifdef ICACHE_STATS_EN
    check_stats("t13");
`endif
    fetch(32'h0, 0, 1'b0);
    // Conflict on index 0, then the evicted line misses again
    fetch(32'h80, 1, 1'b1);
    fetch(32'h0, 3, 1'b0);

    // Reset during MEM_READ
    PC = 32'h380;
    mem_busywait = 1'b1;
    @(negedge CLK);
    chk("rmf_miss", {127'd0, BUSYWAIT}, 128'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rmf_memread", {127'd0, mem_read}, 128'd1);
    RESET = 1'b1;
    #1;
    chk("rmf_memread_clr", {127'd0, mem_read}, 128'd0);
    chk("rmf_busywait_clr", {127'd0, BUSYWAIT}, 128'd0);
    chk("rmf_instr_clr", {96'd0, INSTRUCTION}, 128'd0);
    chk("rmf_addr_clr", {122'd0, mem_address}, 128'd0);
    model_reset();
`ifdef ICACHE_STATS_EN
    check_stats("rmf");
`endif
    @(posedge CLK); #1;
    RESET = 1'b0;
    fetch(32'h0, 2, 1'b0);

    // Randomized fetches biased toward a few hot blocks so hits dominate
    for (int t = 0; t < 300; t++) begin
      pc = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        pc[9:4] = 6'($urandom_range(0, 11));
      end
      fetch(pc, $urandom_range(0, 4), ($urandom_range(0, 1) == 1));
    end

`ifdef ICACHE_STATS_EN
    check_stats("rand");
    // Saturate the hit counter by parking on a resident address
    fetch(32'h0, 1, 1'b0);
    PC = 32'h0;
    repeat (65536) begin
      @(posedge CLK);
      m_hits = sat_inc(m_hits);
    end
    #1;
    chk("hit_saturated", {112'd0, hit_count}, {112'd0, 16'hFFFF});
    check_stats("sat");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
